// File: rtl/fifo_prefetch_pack.sv
// fifo_prefetch_pack
// First-word-fall-through FIFO that packs narrow write beats into wide read
// words. A beat with wr_last closes a partial word early; each read word
// carries its lane count and a last flag.
//
// Ports:
//   clk, rst     - clock (rising edge) and synchronous active-high reset
//   wr_en        - write beat request, accepted when wr_vld is high
//   wr_data      - write beat (one lane)
//   wr_last      - beat closes the current word
//   wr_vld       - FIFO can accept a beat this cycle
//   rd_en        - pop the head word (ignored while rd_vld is low)
//   rd_vld       - head word present on rd_data/rd_cnt/rd_last
//   rd_data      - head word, lane 0 in the LSBs, unused lanes zero
//   rd_cnt       - number of valid lanes in the head word
//   rd_last      - head word was closed by wr_last
//   level        - committed words held (storage plus output register)
//   almost_full  - level >= AFULL_THRESH
module fifo_prefetch_pack #(
    parameter int WR_DATA_WIDTH  = 8,
    parameter int RATIO          = 32,
    parameter int RD_DEPTH_WIDTH = 5,
    parameter int AFULL_THRESH   = 28,
    localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO,
    localparam int CNT_WIDTH     = $clog2(RATIO) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_last,
    output logic                      wr_vld,
    input  logic                      rd_en,
    output logic                      rd_vld,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic [CNT_WIDTH-1:0]      rd_cnt,
    output logic                      rd_last,
    output logic [RD_DEPTH_WIDTH:0]   level,
    output logic                      almost_full
);

    localparam int DEPTH     = 1 << RD_DEPTH_WIDTH;
    localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ENT_WIDTH = RD_DATA_WIDTH + CNT_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0]      IDX_MAX    = IDX_WIDTH'(RATIO - 1);
    localparam logic [RD_DEPTH_WIDTH:0]   LEVEL_FULL = (RD_DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [RD_DEPTH_WIDTH:0]   AFULL_LVL  = (RD_DEPTH_WIDTH + 1)'(AFULL_THRESH);

    // Registered copy of rst; wr_vld is held low until the cycle after
    // reset is released.
    logic                       rst_q_reg;

    // Packer
    logic [IDX_WIDTH-1:0]       idx_reg;
    logic [RATIO-1:0][WR_DATA_WIDTH-1:0] commit_lanes;
    logic [CNT_WIDTH-1:0]       commit_cnt;
    logic [ENT_WIDTH-1:0]       commit_entry;
    logic                       wr_acc;
    logic                       commit;

    // Storage: circular buffer, pointers carry an extra wrap bit
    logic [ENT_WIDTH-1:0]       mem [DEPTH];
    logic [RD_DEPTH_WIDTH:0]    wr_ptr_reg;
    logic [RD_DEPTH_WIDTH:0]    rd_ptr_reg;
    logic                       mem_empty;
    logic                       mem_wr;

    // Prefetch: RAM read stage, then output register
    logic [ENT_WIDTH-1:0]       s1_data_reg;
    logic                       s1_vld_reg;
    logic                       s1_load;
    logic                       s1_to_out;
    logic                       out_vld_reg;
    logic [RD_DATA_WIDTH-1:0]   out_data_reg;
    logic [CNT_WIDTH-1:0]       out_cnt_reg;
    logic                       out_last_reg;
    logic                       out_take;
    logic                       pop;
    logic                       bypass;

    logic [RD_DEPTH_WIDTH:0]    level_reg;
    logic [RD_DEPTH_WIDTH:0]    level_next;
    logic                       afull_reg;

    assign wr_vld = !rst_q_reg && (level_reg < LEVEL_FULL);
    assign wr_acc = wr_en && wr_vld;
    assign commit = wr_acc && ((idx_reg == IDX_MAX) || wr_last);

    // Each lane holds its beat until the word commits. Lanes above the
    // current index are still zero from the previous commit, so the
    // committed word needs no extra masking.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            logic [WR_DATA_WIDTH-1:0] lane_reg;
            logic                     hit;

            assign hit = (idx_reg == IDX_WIDTH'(gi));

            always_ff @(posedge clk) begin
                if (rst || commit) begin
                    lane_reg <= '0;
                end else if (wr_acc && hit) begin
                    lane_reg <= wr_data;
                end
            end

            assign commit_lanes[gi] = hit ? wr_data : lane_reg;
        end
    endgenerate

    assign commit_cnt   = CNT_WIDTH'(idx_reg) + CNT_WIDTH'(1);
    assign commit_entry = {wr_last, commit_cnt, commit_lanes};

    always_ff @(posedge clk) begin
        rst_q_reg <= rst;
        if (rst || commit) begin
            idx_reg <= '0;
        end else if (wr_acc) begin
            idx_reg <= idx_reg + IDX_WIDTH'(1);
        end
    end

    assign pop       = rd_en && out_vld_reg;
    assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
    assign out_take  = !out_vld_reg || pop;
    assign s1_to_out = s1_vld_reg && out_take;
    assign s1_load   = !mem_empty && (!s1_vld_reg || out_take);

    // When the only held word is popped on the same edge a new word
    // commits, the new word goes straight to the output register so the
    // head never goes empty. Nothing is queued behind it, so order holds.
    assign bypass = commit && pop && !s1_vld_reg && mem_empty;
    assign mem_wr = commit && !bypass;

    assign level_next = level_reg + (RD_DEPTH_WIDTH + 1)'(commit)
                                  - (RD_DEPTH_WIDTH + 1)'(pop);

    // Block RAM: write port and registered read port, no reset
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg[RD_DEPTH_WIDTH-1:0]] <= commit_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_data_reg <= mem[rd_ptr_reg[RD_DEPTH_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            s1_vld_reg   <= 1'b0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
            out_cnt_reg  <= '0;
            out_last_reg <= 1'b0;
            level_reg    <= '0;
            afull_reg    <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + (RD_DEPTH_WIDTH + 1)'(1);
            end
            if (s1_load) begin
                rd_ptr_reg <= rd_ptr_reg + (RD_DEPTH_WIDTH + 1)'(1);
            end
            s1_vld_reg <= s1_load || (s1_vld_reg && !s1_to_out);

            if (bypass) begin
                out_vld_reg  <= 1'b1;
                out_data_reg <= commit_entry[RD_DATA_WIDTH-1:0];
                out_cnt_reg  <= commit_cnt;
                out_last_reg <= wr_last;
            end else if (s1_to_out) begin
                out_vld_reg  <= 1'b1;
                out_data_reg <= s1_data_reg[RD_DATA_WIDTH-1:0];
                out_cnt_reg  <= s1_data_reg[RD_DATA_WIDTH +: CNT_WIDTH];
                out_last_reg <= s1_data_reg[ENT_WIDTH-1];
            end else if (pop) begin
                out_vld_reg <= 1'b0;
            end

            level_reg <= level_next;
            afull_reg <= (level_next >= AFULL_LVL);
        end
    end

    assign rd_vld      = out_vld_reg;
    assign rd_data     = out_data_reg;
    assign rd_cnt      = out_cnt_reg;
    assign rd_last     = out_last_reg;
    assign level       = level_reg;
    assign almost_full = afull_reg;

endmodule

// File: tb/tb_fifo_prefetch_pack.sv
// Testbench for fifo_prefetch_pack: directed framing/full/wrap/reset cases on
// the default 8x32 configuration, plus a randomized run on a 16-bit RATIO=1
// instance. Expected words come from a queue-based reference model.
module tb_fifo_prefetch_pack;

    localparam int W     = 8;
    localparam int R     = 32;
    localparam int RDW   = W * R;
    localparam int DEPTH = 32;
    localparam int AFULL = 28;
    localparam int W1    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (8-bit lanes, 32 lanes per word)
    logic           wr_en = 1'b0;
    logic [W-1:0]   wr_data = '0;
    logic           wr_last = 1'b0;
    logic           wr_vld;
    logic           rd_en = 1'b0;
    logic           rd_vld;
    logic [RDW-1:0] rd_data;
    logic [5:0]     rd_cnt;
    logic           rd_last;
    logic [5:0]     level;
    logic           almost_full;

    // RATIO=1 instance (16-bit)
    logic           wr_en1 = 1'b0;
    logic [W1-1:0]  wr_data1 = '0;
    logic           wr_last1 = 1'b0;
    logic           wr_vld1;
    logic           rd_en1 = 1'b0;
    logic           rd_vld1;
    logic [W1-1:0]  rd_data1;
    logic [0:0]     rd_cnt1;
    logic           rd_last1;
    logic [5:0]     level1;
    logic           almost_full1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_prefetch_pack #(
        .WR_DATA_WIDTH(W), .RATIO(R), .RD_DEPTH_WIDTH(5), .AFULL_THRESH(AFULL)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .wr_vld(wr_vld), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
        .rd_cnt(rd_cnt), .rd_last(rd_last), .level(level), .almost_full(almost_full)
    );

    fifo_prefetch_pack #(
        .WR_DATA_WIDTH(W1), .RATIO(1), .RD_DEPTH_WIDTH(5), .AFULL_THRESH(AFULL)
    ) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .wr_last(wr_last1),
        .wr_vld(wr_vld1), .rd_en(rd_en1), .rd_vld(rd_vld1), .rd_data(rd_data1),
        .rd_cnt(rd_cnt1), .rd_last(rd_last1), .level(level1), .almost_full(almost_full1)
    );

    task automatic chk(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model, main instance ----------------
    logic [W-1:0]   m_beats[$];
    logic [RDW-1:0] exp_data[$];
    int             exp_cnt[$];
    bit             exp_last[$];
    int             m_level = 0;
    bit             m_rstq  = 1'b1;
    bit             a_acc, a_pop, a_com;
    logic [RDW-1:0] a_word;

    // Input side: predicts acceptance, packs beats into words, tracks level
    always @(negedge clk) begin
        chk("wr_vld", RDW'(wr_vld), RDW'(!m_rstq && (m_level < DEPTH)));
        chk("level", RDW'(level), RDW'(m_level));
        chk("almost_full", RDW'(almost_full), RDW'(m_level >= AFULL));
        if (rst) begin
            m_rstq  = 1'b1;
            m_level = 0;
            m_beats.delete();
            exp_data.delete();
            exp_cnt.delete();
            exp_last.delete();
        end else begin
            a_acc = wr_en && !m_rstq && (m_level < DEPTH);
            a_pop = rd_en && rd_vld;
            a_com = 1'b0;
            if (a_acc) begin
                m_beats.push_back(wr_data);
                if (wr_last || m_beats.size() == R) begin
                    a_word = '0;
                    foreach (m_beats[i]) a_word[i*W +: W] = m_beats[i];
                    exp_data.push_back(a_word);
                    exp_cnt.push_back(m_beats.size());
                    exp_last.push_back(wr_last);
                    m_beats.delete();
                    a_com = 1'b1;
                end
            end
            m_level = m_level + int'(a_com) - int'(a_pop);
            m_rstq  = 1'b0;
        end
    end

    // Output side: compares every popped word against the queue head
    always @(negedge clk) begin
        if (!rst && rd_vld) begin
            if (exp_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_vld_empty actual=1 required=0");
            end else if (rd_en) begin
                chk("pop_data", rd_data, exp_data[0]);
                chk("pop_cnt", RDW'(rd_cnt), RDW'(exp_cnt[0]));
                chk("pop_last", RDW'(rd_last), RDW'(exp_last[0]));
                void'(exp_data.pop_front());
                void'(exp_cnt.pop_front());
                void'(exp_last.pop_front());
            end
        end
    end

    // ---------------- reference model, RATIO=1 instance ----------------
    logic [W1:0] exp1_q[$];   // {last, data}
    int          m1_level = 0;
    bit          m1_rstq  = 1'b1;
    bit          c_acc, c_pop;

    always @(negedge clk) begin
        chk("r1_wr_vld", RDW'(wr_vld1), RDW'(!m1_rstq && (m1_level < DEPTH)));
        chk("r1_level", RDW'(level1), RDW'(m1_level));
        chk("r1_almost_full", RDW'(almost_full1), RDW'(m1_level >= AFULL));
        if (rst) begin
            m1_rstq  = 1'b1;
            m1_level = 0;
            exp1_q.delete();
        end else begin
            c_acc = wr_en1 && !m1_rstq && (m1_level < DEPTH);
            c_pop = rd_en1 && rd_vld1;
            if (c_acc) exp1_q.push_back({wr_last1, wr_data1});
            m1_level = m1_level + int'(c_acc) - int'(c_pop);
            m1_rstq  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_vld1) begin
            chk("r1_rd_cnt", RDW'(rd_cnt1), RDW'(1));
            if (exp1_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL r1_rd_vld_empty actual=1 required=0");
            end else if (rd_en1) begin
                chk("r1_pop_data", RDW'(rd_data1), RDW'(exp1_q[0][W1-1:0]));
                chk("r1_pop_last", RDW'(rd_last1), RDW'(exp1_q[0][W1]));
                void'(exp1_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit we, input logic [W-1:0] d, input bit last, input bit re);
        wr_en = we; wr_data = d; wr_last = last; rd_en = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_rd_vld", RDW'(rd_vld), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_cnt", RDW'(rd_cnt), '0);
        chk("rst_rd_last", RDW'(rd_last), '0);
        chk("rst_level", RDW'(level), '0);
        chk("rst_almost_full", RDW'(almost_full), '0);
        chk("rst_wr_vld", RDW'(wr_vld), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("wr_vld_after_rst", RDW'(wr_vld), RDW'(1));
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("drain_rd_vld", RDW'(rd_vld), '0);
        chk("drain_level", RDW'(level), '0);
        chk("drain_model_empty", RDW'(exp_data.size()), '0);
    endtask

    logic [RDW-1:0] exp_word;
    int p_wr, p_rd;

    initial begin
        do_reset(2);

        // Full word 0x00..0x1F, valid two edges after the last beat
        for (int i = 0; i < R; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        chk("lat_e0_rd_vld", RDW'(rd_vld), '0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("lat_e1_rd_vld", RDW'(rd_vld), '0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("lat_e2_rd_vld", RDW'(rd_vld), RDW'(1));
        exp_word = '0;
        for (int i = 0; i < R; i++) exp_word[i*W +: W] = W'(i);
        chk("full_word_data", rd_data, exp_word);
        chk("full_word_cnt", RDW'(rd_cnt), RDW'(32));
        chk("full_word_last", RDW'(rd_last), '0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("last_pop_rd_vld", RDW'(rd_vld), '0);

        // Partial word followed by a one-lane word
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("partial_data", rd_data, RDW'(24'hC3B2A1));
        chk("partial_cnt", RDW'(rd_cnt), RDW'(3));
        chk("partial_last", RDW'(rd_last), RDW'(1));
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("one_lane_vld", RDW'(rd_vld), RDW'(1));
        chk("one_lane_data", rd_data, RDW'(8'h5A));
        chk("one_lane_cnt", RDW'(rd_cnt), RDW'(1));
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Fill to full, drop extra beats, drain in order; three rounds wrap
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                cyc(1'b1, W'($urandom), 1'b1, 1'b0);
                chk("fill_level", RDW'(level), RDW'(k));
                chk("fill_afull", RDW'(almost_full), RDW'(k >= AFULL));
            end
            chk("full_wr_vld", RDW'(wr_vld), '0);
            for (int k = 0; k < 3; k++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
            chk("full_drop_level", RDW'(level), RDW'(DEPTH));
            drain(DEPTH);
        end

        // Commit and pop together at level 31
        for (int k = 0; k < DEPTH - 1; k++) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, W'($urandom), 1'b1, 1'b1);
        chk("sim31_level", RDW'(level), RDW'(DEPTH - 1));
        cyc(1'b1, W'($urandom), 1'b1, 1'b0);
        chk("to_full_level", RDW'(level), RDW'(DEPTH));
        drain(DEPTH);

        // Commit and pop together at level 1
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b1, 1'b1);
        chk("sim1_rd_vld", RDW'(rd_vld), RDW'(1));
        chk("sim1_level", RDW'(level), RDW'(1));
        chk("sim1_data", rd_data, RDW'(8'h22));
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Reset in the middle of a packet
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
        do_reset(1);
        for (int i = 0; i < R; i++) cyc(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        exp_word = '0;
        for (int i = 0; i < R; i++) exp_word[i*W +: W] = W'(8'h80 + i);
        chk("post_rst_data", rd_data, exp_word);
        chk("post_rst_cnt", RDW'(rd_cnt), RDW'(32));
        drain(1);

        // RATIO=1 randomized push/pop
        for (int i = 0; i < 1000; i++) begin
            if (i < 300) begin p_wr = 85; p_rd = 25; end
            else if (i < 650) begin p_wr = 50; p_rd = 50; end
            else begin p_wr = 25; p_rd = 80; end
            wr_en1   = ($urandom_range(0, 99) < p_wr);
            rd_en1   = ($urandom_range(0, 99) < p_rd);
            wr_data1 = W1'($urandom);
            wr_last1 = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
        end
        wr_en1 = 1'b0;
        rd_en1 = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        rd_en1 = 1'b0;
        chk("r1_drain_rd_vld", RDW'(rd_vld1), '0);
        chk("r1_drain_model_empty", RDW'(exp1_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_prefetch_pack.md
# fifo_prefetch_pack

Synchronous, single-clock, first-word-fall-through FIFO that packs narrow write beats into wide read words with a parametrised width ratio. Adds packet framing: a `wr_last` beat closes a partial word, and the read side carries a lane count and last flag. It sits between byte-serial sources (UART receive path) and wide consumers (weight/feature loaders) in the accelerator datapath. It generalises the existing fixed 8→256 prefetch FIFO with occupancy and almost-full reporting.

## Interface
- `WR_DATA_WIDTH`, 8: write beat width (lane width).
- `RATIO`, 32: lanes per read word; power of two, 1..128. Read width is `RD_DATA_WIDTH = WR_DATA_WIDTH*RATIO`.
- `RD_DEPTH_WIDTH`, 5: storage depth is `2^RD_DEPTH_WIDTH` read words.
- `AFULL_THRESH`, 28: `almost_full` threshold in read words, 1..depth.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write beat request.
- `wr_data` in WR_DATA_WIDTH: write beat.
- `wr_last` in 1: beat closes the current word; sampled with `wr_en`.
- `wr_vld` out 1: FIFO can accept a beat this cycle.
- `rd_en` in 1: pop the head word.
- `rd_vld` out 1: head word present on `rd_data`.
- `rd_data` out RD_DATA_WIDTH: head word; lane 0 in the LSBs.
- `rd_cnt` out clog2(RATIO)+1: number of valid lanes in the head word, 1..RATIO.
- `rd_last` out 1: head word was closed by `wr_last`.
- `level` out RD_DEPTH_WIDTH+1: committed words held, 0..depth.
- `almost_full` out 1: `level >= AFULL_THRESH`.

## Operation
- **Beat acceptance:** a beat is accepted when `wr_en && wr_vld`. Beats with `wr_vld` low are dropped; no state changes.
- **wr_vld:** `wr_vld = !rst_q && (level < depth)`. It is conservative: it goes low whenever storage is full, even mid-word.
- **Packer:**
  - A lane index counts 0..RATIO-1. Each accepted beat is written into lane `idx` of the pack register.
  - The word commits to storage when `idx == RATIO-1` or `wr_last` = 1.
  - On commit, store `rd_cnt = idx+1` and `rd_last = wr_last`. Lanes ≥ `idx+1` are zero. Then `idx` returns to 0.
  - `wr_last` on lane 0 commits a one-lane word.
  - With `RATIO=1`, every beat commits; `rd_cnt = 1` always.
- **Storage and prefetch:**
  - Storage is a circular buffer with RD_DEPTH_WIDTH-bit pointers plus a wrap bit, feeding an output prefetch register.
  - `level` counts storage words plus the output register.
  - Full is `level == depth`; empty is `level == 0`.
  - Pointers wrap modulo depth without a bubble.
- **Pop:** occurs when `rd_en && rd_vld`. The next word appears the following cycle, so back-to-back pops run at one word per cycle. `rd_en` with `rd_vld` low is ignored.
- **Simultaneous commit and pop:** `level` is unchanged. This is legal at any level, including full−1 → commit → full.
- **Reset:**
  - Clears pointers, packer, `idx`, and all flags; any partial word is discarded.
  - Outputs during and after reset: `rd_vld = 0`, `rd_data = 0`, `rd_cnt = 0`, `rd_last = 0`, `level = 0`, `almost_full = 0`, `wr_vld = 0`.
  - `wr_vld` rises the cycle after `rst` deasserts.
  - A reset mid-packet drops all data.

## Timing
- All outputs are registered except `wr_vld`, which decodes registered `level` (no combinational path from `wr_en`/`rd_en`).
- **Write-to-read latency:** a committing beat accepted at edge E into an empty FIFO gives `rd_vld = 1` with valid data after edge E+2.
- **Pop timing:** a pop at edge P updates `rd_data`/`rd_vld` after edge P. A pop of the last word drops `rd_vld` after P.
- **level / almost_full:** update one edge after the commit or pop that changes them.
- **Write throughput:** one beat per cycle while `wr_vld` = 1.
- **Full-word latency:** RATIO beats to a full word.

## Test plan
- **Full word:** reset, then write bytes 0x00..0x1F (32 beats, no `wr_last`). Expect `rd_vld` two edges after beat 31; `rd_data` = 0x1F1E…0100; `rd_cnt` = 32; `rd_last` = 0.
- **Partial word:** write 0xA1, 0xB2, 0xC3 with `wr_last` on 0xC3. Expect `rd_data` = 0x…00C3B2A1 (upper 29 lanes zero); `rd_cnt` = 3; `rd_last` = 1. Follow with a single `wr_last` beat 0x5A: expect `rd_cnt` = 1.
- **Full and wrap:** commit 32 words with no reads. Expect `level` = 32, `almost_full` from `level` 28, and `wr_vld` = 0; a 33rd word's beats are dropped. Then pop all 32 in consecutive cycles and expect in-order data. Repeat twice to exercise pointer wrap.
- **Simultaneous commit and pop:** at `level` 31, commit and pop on the same edge. Expect `level` to stay 31 and ordering to be preserved. At `level` 1, do the same and expect `rd_vld` to stay high.
- **Reset mid-packet:** write 10 beats, then hold `rst` for 1 cycle. Expect all outputs zero and `wr_vld` = 0 during reset. Then write a 32-beat word: `rd_data` must contain only the new beats.
- **RATIO=1, WR_DATA_WIDTH=16:** random push/pop for 1000 cycles against a scoreboard model. Expect no loss or reorder, `rd_cnt` ≡ 1, and `level` matching the model every cycle.
